// File: rtl/io_map_pkg.sv
// IO map constants shared by the IO hub and its peripherals.
// Provides bus base addresses and input-port register word indices.
package io_map_pkg;

    localparam logic [31:0] ADDR_IO  = 32'hF000_0000;
    localparam logic [31:0] ADDR_SEG = 32'hF000_0000;
    localparam logic [31:0] ADDR_LED = 32'hF100_0000;
    localparam logic [31:0] ADDR_IN  = 32'hF200_0000;

    localparam logic [3:0] REG_SW    = 4'd0;
    localparam logic [3:0] REG_KEY   = 4'd1;
    localparam logic [3:0] REG_PRESS = 4'd2;
    localparam logic [3:0] REG_COUNT = 4'd3;
    localparam logic [3:0] REG_IRQEN = 4'd4;

endpackage

// File: rtl/in_debounce.sv
// One-bit 2-FF synchroniser followed by a stable-count debouncer.
// Ports: clk, resetn (async active-low), din (raw async), dout (debounced).
module in_debounce
    import io_map_pkg::*;
#(
    parameter int DB_CYCLES = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic dout
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            dout <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                // level held long enough: accept it
                dout <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped switch/key input port: debounced levels, sticky press
// flags, press counter and (with KEY_IRQ_EN defined) a maskable key irq.
// Ports: clk, resetn, sw_in, key_n, cs/we/addr/wdata (bus), rdata, irq.
module io_input_port
    import io_map_pkg::*;
#(
    parameter int NSW       = 10,
    parameter int NKEY      = 4,
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [NSW-1:0]  sw_in,
    input  logic [NKEY-1:0] key_n,
    input  logic            cs,
    input  logic            we,
    input  logic [3:0]      addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic            irq
);

    localparam int NB = NSW + NKEY;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    db;
    logic [NSW-1:0]   sw_db;
    logic [NKEY-1:0]  key_db;
    logic [NKEY-1:0]  key_q;
    logic [NKEY-1:0]  press_ev;
    logic [NKEY-1:0]  press;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] ev_cnt;
    logic [NKEY-1:0]  irq_en;
    logic [31:0]      rd_val;
    logic             wr;
    logic             rd;

    // keys are inverted ahead of the synchroniser so reset (0) means released
    assign raw    = {~key_n, sw_in};
    assign sw_db  = db[NSW-1:0];
    assign key_db = db[NSW +: NKEY];

    for (genvar i = 0; i < NB; i++) begin : g_db
        in_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
            .clk    (clk),
            .resetn (resetn),
            .din    (raw[i]),
            .dout   (db[i])
        );
    end

    assign press_ev = key_db & ~key_q;
    assign wr       = cs & we;
    assign rd       = cs & ~we;

    always_comb begin
        ev_cnt = '0;
        for (int i = 0; i < NKEY; i++) begin
            ev_cnt = ev_cnt + CNT_W'(press_ev[i]);
        end
    end

    always_comb begin
        rd_val = '0;
        unique case (addr)
            REG_SW:    rd_val = 32'(sw_db);
            REG_KEY:   rd_val = 32'(key_db);
            REG_PRESS: rd_val = 32'(press);
            REG_COUNT: rd_val = 32'(count);
            REG_IRQEN: rd_val = 32'(irq_en);
            default:   rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q <= '0;
            press <= '0;
            count <= '0;
            rdata <= '0;
        end else begin
            key_q <= key_db;
            if (wr && addr == REG_PRESS) begin
                // new press wins over a same-cycle clear
                press <= (press & ~wdata[NKEY-1:0]) | press_ev;
            end else begin
                press <= press | press_ev;
            end
            if (wr && addr == REG_COUNT) begin
                count <= ev_cnt;
            end else begin
                count <= count + ev_cnt;
            end
            if (rd) begin
                rdata <= rd_val;
            end
        end
    end

`ifdef KEY_IRQ_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            irq_en <= '0;
            irq    <= 1'b0;
        end else begin
            if (wr && addr == REG_IRQEN) begin
                irq_en <= wdata[NKEY-1:0];
            end
            irq <= |(press & irq_en);
        end
    end
`else
    assign irq_en = '0;
    assign irq    = 1'b0;
`endif

endmodule

// File: tb/tb_io_input_port.sv
// Directed testbench for io_input_port (DB_CYCLES=4, CNT_W=4).
// Define KEY_IRQ_EN for both files to exercise the irq path.
module tb_io_input_port;

    logic        clk = 1'b0;
    logic        resetn;
    logic [9:0]  sw_in;
    logic [3:0]  key_n;
    logic        cs;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    io_input_port #(
        .NSW(10), .NKEY(4), .DB_CYCLES(4), .CNT_W(4)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .sw_in  (sw_in),
        .key_n  (key_n),
        .cs     (cs),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; addr = a; wdata = d;
        wait_clk(1);
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        cs = 1'b1; we = 1'b0; addr = a;
        wait_clk(1);
        cs = 1'b0;
        d = rdata;
    endtask

    task automatic press_key(input logic [3:0] m);
        key_n = ~m;
        wait_clk(10);
        key_n = 4'hF;
        wait_clk(10);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        resetn = 1'b0; key_n = 4'h0; sw_in = '0;
        cs = 0; we = 0; addr = 0; wdata = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 0", rdata);
        end
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL reset_irq got %b want 0", irq);
        end
        @(posedge clk); #1;
        resetn = 1'b1;
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL rst_press_early got %h want 0", v);
        end
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL rst_count_early got %h want 0", v);
        end
        wait_clk(10);
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'hF) begin
            errors++; $display("FAIL rst_press_late got %h want f", v);
        end
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h4) begin
            errors++; $display("FAIL rst_count_late got %h want 4", v);
        end
        bus_read(4'd1, v);
        checks++;
        if (v !== 32'hF) begin
            errors++; $display("FAIL rst_key got %h want f", v);
        end
        key_n = 4'hF;
        wait_clk(10);
        bus_write(4'd2, 32'hF);
        bus_write(4'd3, 32'h0);
    endtask

    task automatic test_switches;
        logic [31:0] v;
        sw_in = 10'h2A5;
        wait_clk(8);
        bus_read(4'd0, v);
        checks++;
        if (v !== 32'h2A5) begin
            errors++; $display("FAIL sw_level got %h want 2a5", v);
        end
        sw_in = 10'h15A;
        wait_clk(2);
        sw_in = 10'h2A5;
        wait_clk(8);
        bus_read(4'd0, v);
        checks++;
        if (v !== 32'h2A5) begin
            errors++; $display("FAIL sw_glitch got %h want 2a5", v);
        end
    endtask

    task automatic test_press_w1c;
        logic [31:0] v;
        key_n = 4'b1101;
        wait_clk(10);
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL press_flag got %h want 2", v);
        end
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL press_count got %h want 1", v);
        end
        bus_write(4'd2, 32'h2);
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL w1c_clear got %h want 0", v);
        end
        key_n = 4'hF;
        wait_clk(10);
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL release_flag got %h want 0", v);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] v;
        // event fires between the 6th and 7th edge after the key change
        key_n = 4'b1110;
        wait_clk(6);
        bus_write(4'd2, 32'h1);
        bus_read(4'd2, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL w1c_vs_set got %h want 1", v);
        end
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL count_before got %h want 2", v);
        end
        key_n = 4'hF;
        wait_clk(10);
        bus_write(4'd2, 32'hF);
        key_n = 4'b1101;
        wait_clk(6);
        bus_write(4'd3, 32'h0);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++; $display("FAIL count_wr_vs_ev got %h want 1", v);
        end
        key_n = 4'hF;
        wait_clk(10);
        bus_write(4'd2, 32'hF);
    endtask

    task automatic test_count_wrap;
        logic [31:0] v;
        bus_write(4'd3, 32'h0);
        press_key(4'hF);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h4) begin
            errors++; $display("FAIL popcount got %h want 4", v);
        end
        press_key(4'hF);
        press_key(4'hF);
        press_key(4'h7);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'hF) begin
            errors++; $display("FAIL count_max got %h want f", v);
        end
        press_key(4'h8);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL count_wrap got %h want 0", v);
        end
        press_key(4'h5);
        bus_read(4'd3, v);
        checks++;
        if (v !== 32'h2) begin
            errors++; $display("FAIL count_after_wrap got %h want 2", v);
        end
        bus_write(4'd2, 32'hF);
    endtask

    task automatic test_unmapped;
        logic [31:0] v;
        bus_write(4'd9, 32'hFFFF_FFFF);
        bus_read(4'd9, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL unmapped got %h want 0", v);
        end
    endtask

    task automatic test_irq;
        logic [31:0] v;
`ifdef KEY_IRQ_EN
        bus_write(4'd4, 32'h4);
        bus_read(4'd4, v);
        checks++;
        if (v !== 32'h4) begin
            errors++; $display("FAIL irqen_rd got %h want 4", v);
        end
        press_key(4'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_masked got %b want 0", irq);
        end
        bus_write(4'd2, 32'hF);
        key_n = 4'b1011;
        wait_clk(7);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_early got %b want 0", irq);
        end
        wait_clk(1);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_set got %b want 1", irq);
        end
        key_n = 4'hF;
        wait_clk(10);
        bus_write(4'd2, 32'h4);
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_hold got %b want 1", irq);
        end
        wait_clk(1);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear got %b want 0", irq);
        end
`else
        bus_write(4'd4, 32'hF);
        bus_read(4'd4, v);
        checks++;
        if (v !== 32'h0) begin
            errors++; $display("FAIL irqen_absent got %h want 0", v);
        end
        press_key(4'hF);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_tied got %b want 0", irq);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_switches();
        test_press_w1c();
        test_simultaneous();
        test_count_wrap();
        test_unmapped();
        test_irq();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
